if_fetch: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter register.
- Takes the current PC value and issues one instruction-memory request at a time using a req/gnt + rvalid handshake.
- Drives the PC advance enable, and captures the returned instruction into the IF/ID pipeline register.
- A one-entry skid buffer absorbs ID-stage stalls; a flush input squashes wrong-path fetches after branch redirects.

---
 rtl/if_fetch.sv | 152 +++++++++++++++
 tb/tb_if_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding req/gnt + rvalid memory access,
// IF/ID output register backed by a one-entry skid buffer, flush squashing.
module if_fetch #(
    parameter int              AW        = 32,
    parameter int              DW        = 32,
    parameter logic [DW-1:0]   NOP_INSTR = 32'h00000013
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [AW-1:0] pc_in,
    output logic          pc_en,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    input  logic          id_ready,
    input  logic          flush,
    output logic          if_id_valid,
    output logic [AW-1:0] if_id_pc,
    output logic [AW-1:0] if_id_pc4,
    output logic [DW-1:0] if_id_instr,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t        state, state_nxt;
    logic          discard;
    logic [AW-1:0] cap_pc;
    logic          out_valid;
    logic [AW-1:0] out_pc;
    logic [DW-1:0] out_instr;
    logic          skid_valid;
    logic          skid_valid_nxt;
    logic [AW-1:0] skid_pc;
    logic [DW-1:0] skid_instr;
    logic          accept;
    logic          to_out;
    logic          to_skid;
    logic          consume;

    // A response is taken only in WAIT, when not marked wrong-path and not being flushed.
    assign accept  = (state == WAIT) && imem_rvalid && !discard && !flush;
    assign to_out  = accept && (!out_valid || id_ready);
    assign to_skid = accept && out_valid && !id_ready;
    assign consume = id_ready && out_valid;

    always_comb begin
        skid_valid_nxt = skid_valid;
        if (flush)
            skid_valid_nxt = 1'b0;
        else if (to_skid)
            skid_valid_nxt = 1'b1;
        else if (consume && !accept)
            skid_valid_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!skid_valid && !flush) state_nxt = REQ;
            REQ: begin
                if (flush)
                    state_nxt = IDLE;
                else if (imem_gnt)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (discard || flush || skid_valid_nxt)
                        state_nxt = IDLE;
                    else
                        state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        pc_en    = 1'b0;
        if (state == REQ) begin
            imem_req = 1'b1;
            pc_en    = imem_gnt && !flush;
        end
    end

    assign imem_addr = {pc_in[AW-1:2], 2'b00};
    assign state_dbg = state;

    // Discard marks an in-flight response as wrong-path after a flush in WAIT.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            discard <= 1'b0;
            cap_pc  <= '0;
        end else begin
            if (state == WAIT) begin
                if (imem_rvalid)
                    discard <= 1'b0;
                else if (flush)
                    discard <= 1'b1;
            end
            if (pc_en)
                cap_pc <= pc_in;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= NOP_INSTR;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (to_out) begin
                out_valid <= 1'b1;
                out_pc    <= cap_pc;
                out_instr <= imem_rdata;
            end else if (consume) begin
                out_valid <= skid_valid;
                if (skid_valid) begin
                    out_pc    <= skid_pc;
                    out_instr <= skid_instr;
                end
            end
            skid_valid <= skid_valid_nxt;
            if (to_skid) begin
                skid_pc    <= cap_pc;
                skid_instr <= imem_rdata;
            end
        end
    end

    assign if_id_valid = out_valid;
    assign if_id_pc    = out_pc;
    assign if_id_pc4   = out_pc + AW'(4);
    assign if_id_instr = out_valid ? out_instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: each task drives a scenario cycle by cycle and
// compares outputs against hand-computed values.
module tb_if_fetch;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [DW-1:0] NOP = 32'h00000013;

    logic          clk;
    logic          clr;
    logic [AW-1:0] pc_in;
    logic          pc_en;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          id_ready;
    logic          flush;
    logic          if_id_valid;
    logic [AW-1:0] if_id_pc;
    logic [AW-1:0] if_id_pc4;
    logic [DW-1:0] if_id_instr;
    logic [1:0]    state_dbg;

    int errors = 0;
    int checks = 0;

    if_fetch #(.AW(AW), .DW(DW), .NOP_INSTR(NOP)) dut (
        .clk(clk), .clr(clr), .pc_in(pc_in), .pc_en(pc_en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_ready(id_ready),
        .flush(flush), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr), .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        clr = 1'b0; pc_in = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; id_ready = 1'b0; flush = 1'b0;
        cyc();
        cyc();
        clr = 1'b1;
    endtask

    // Two fetches (0x0 -> 0x11111111, 0x4 -> 0x22222222) with id_ready low; ends in IDLE, skid full.
    task automatic fill_two();
        id_ready = 1'b0; imem_gnt = 1'b1; pc_in = 32'h0;
        cyc();
        cyc();
        pc_in = 32'h4; imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
        cyc();
        imem_rvalid = 1'b0;
        cyc();
        pc_in = 32'h8; imem_rvalid = 1'b1; imem_rdata = 32'h22222222;
        cyc();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req actual=%0h expected=0", imem_req); end checks++;
        if (pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en actual=%0h expected=0", pc_en); end checks++;
        if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%0h expected=0", if_id_valid); end checks++;
        if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc actual=%0h expected=0", if_id_pc); end checks++;
        if (if_id_pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc4 actual=%0h expected=4", if_id_pc4); end checks++;
        if (if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr actual=%0h expected=%0h", if_id_instr, NOP); end checks++;
    endtask

    task automatic test_basic();
        do_reset();
        pc_in = 32'h0; imem_gnt = 1'b1; id_ready = 1'b1;
        cyc();
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL basic_req actual=%0h/%0h expected=1/0", imem_req, imem_addr); end checks++;
        if (pc_en !== 1'b1) begin errors++; $display("FAIL basic_pc_en actual=%0h expected=1", pc_en); end checks++;
        cyc();
        pc_in = 32'h4; imem_rvalid = 1'b1; imem_rdata = 32'h00500093;
        #1;
        if (pc_en !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL basic_wait actual=%0h/%0h expected=0/0", pc_en, imem_req); end checks++;
        cyc();
        imem_rvalid = 1'b0;
        #1;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h4) begin errors++; $display("FAIL basic_out actual=%0h/%0h/%0h expected=1/0/4", if_id_valid, if_id_pc, if_id_pc4); end checks++;
        if (if_id_instr !== 32'h00500093) begin errors++; $display("FAIL basic_instr actual=%0h expected=00500093", if_id_instr); end checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next_req actual=%0h/%0h expected=1/4", imem_req, imem_addr); end checks++;
    endtask

    task automatic test_skid();
        do_reset();
        fill_two();
        #1;
        if (if_id_instr !== 32'h11111111 || if_id_pc !== 32'h0) begin errors++; $display("FAIL skid_hold actual=%0h@%0h expected=11111111@0", if_id_instr, if_id_pc); end checks++;
        for (int i = 0; i < 3; i++) begin
            if (imem_req !== 1'b0) begin errors++; $display("FAIL skid_no_req cycle=%0d actual=%0h expected=0", i, imem_req); end checks++;
            cyc();
        end
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        #1;
        if (if_id_valid !== 1'b1 || if_id_instr !== 32'h22222222) begin errors++; $display("FAIL skid_move actual=%0h/%0h expected=1/22222222", if_id_valid, if_id_instr); end checks++;
        if (if_id_pc !== 32'h4 || if_id_pc4 !== 32'h8) begin errors++; $display("FAIL skid_move_pc actual=%0h/%0h expected=4/8", if_id_pc, if_id_pc4); end checks++;
        cyc();
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL skid_resume actual=%0h/%0h expected=1/8", imem_req, imem_addr); end checks++;
    endtask

    task automatic test_flush_wait();
        do_reset();
        pc_in = 32'h0; imem_gnt = 1'b1; id_ready = 1'b1;
        cyc();
        cyc();
        imem_gnt = 1'b0; flush = 1'b1; pc_in = 32'h100;
        cyc();
        flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        cyc();
        imem_rvalid = 1'b0;
        #1;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin errors++; $display("FAIL flushw_drop actual=%0h/%0h expected=0/%0h", if_id_valid, if_id_instr, NOP); end checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL flushw_idle actual=%0h expected=0", imem_req); end checks++;
        cyc();
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL flushw_redirect actual=%0h/%0h expected=1/100", imem_req, imem_addr); end checks++;
    endtask

    task automatic test_flush_rvalid();
        do_reset();
        fill_two();
        flush = 1'b1; pc_in = 32'h200;
        cyc();
        flush = 1'b0;
        #1;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin errors++; $display("FAIL flushr_clear actual=%0h/%0h expected=0/%0h", if_id_valid, if_id_instr, NOP); end checks++;
        cyc();
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || pc_en !== 1'b1) begin errors++; $display("FAIL flushr_req actual=%0h/%0h/%0h expected=1/200/1", imem_req, imem_addr, pc_en); end checks++;
        cyc();
        flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h33333333;
        cyc();
        flush = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b1;
        #1;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin errors++; $display("FAIL flushr_drop actual=%0h/%0h expected=0/%0h", if_id_valid, if_id_instr, NOP); end checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL flushr_idle actual=%0h expected=0", imem_req); end checks++;
        cyc();
        if (if_id_valid !== 1'b0) begin errors++; $display("FAIL flushr_skid_empty actual=%0h expected=0", if_id_valid); end checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL flushr_restart actual=%0h expected=1", imem_req); end checks++;
    endtask

    task automatic test_gnt_stall();
        do_reset();
        pc_in = 32'h43; imem_gnt = 1'b0; id_ready = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            if (imem_req !== 1'b1 || imem_addr !== 32'h40 || pc_en !== 1'b0) begin errors++; $display("FAIL stall cycle=%0d actual=%0h/%0h/%0h expected=1/40/0", i, imem_req, imem_addr, pc_en); end checks++;
            cyc();
        end
        imem_gnt = 1'b1;
        #1;
        if (pc_en !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL stall_gnt actual=%0h/%0h expected=1/40", pc_en, imem_addr); end checks++;
        cyc();
        imem_gnt = 1'b0; pc_in = 32'h47; imem_rvalid = 1'b1; imem_rdata = 32'hABCD0001;
        #1;
        if (pc_en !== 1'b0) begin errors++; $display("FAIL stall_pulse_once actual=%0h expected=0", pc_en); end checks++;
        cyc();
        imem_rvalid = 1'b0;
        #1;
        if (if_id_pc !== 32'h43 || if_id_pc4 !== 32'h47 || if_id_instr !== 32'hABCD0001) begin errors++; $display("FAIL stall_unaligned actual=%0h/%0h/%0h expected=43/47/abcd0001", if_id_pc, if_id_pc4, if_id_instr); end checks++;
    endtask

    task automatic test_wrap();
        do_reset();
        pc_in = 32'hFFFFFFFC; imem_gnt = 1'b1; id_ready = 1'b1;
        cyc();
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000006F;
        cyc();
        imem_rvalid = 1'b0;
        #1;
        if (if_id_pc !== 32'hFFFFFFFC || if_id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 actual=%0h/%0h expected=fffffffc/0", if_id_pc, if_id_pc4); end checks++;
    endtask

    task automatic test_reset_midwait();
        do_reset();
        pc_in = 32'h80; imem_gnt = 1'b1; id_ready = 1'b0;
        cyc();
        cyc();
        pc_in = 32'h84; imem_rvalid = 1'b1; imem_rdata = 32'h55555555;
        cyc();
        imem_rvalid = 1'b0;
        cyc();
        imem_gnt = 1'b0;
        #1;
        if (if_id_valid !== 1'b1) begin errors++; $display("FAIL midwait_pre actual=%0h expected=1", if_id_valid); end checks++;
        clr = 1'b0;
        #1;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h4) begin errors++; $display("FAIL midwait_async actual=%0h/%0h/%0h/%0h expected=0/%0h/0/4", if_id_valid, if_id_instr, if_id_pc, if_id_pc4, NOP); end checks++;
        if (imem_req !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL midwait_req actual=%0h/%0h expected=0/0", imem_req, pc_en); end checks++;
        cyc();
        clr = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h99999999; pc_in = 32'hC0;
        cyc();
        imem_rvalid = 1'b0;
        #1;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin errors++; $display("FAIL midwait_stray actual=%0h/%0h expected=0/%0h", if_id_valid, if_id_instr, NOP); end checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC0) begin errors++; $display("FAIL midwait_restart actual=%0h/%0h expected=1/c0", imem_req, imem_addr); end checks++;
    endtask

    initial begin
        clr = 1'b0; pc_in = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; id_ready = 1'b0; flush = 1'b0;
        test_reset();
        test_basic();
        test_skid();
        test_flush_wait();
        test_flush_rvalid();
        test_gnt_stall();
        test_wrap();
        test_reset_midwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
